// File: rtl/glyph_line_scheduler.sv
// glyph_line_scheduler: walks a text buffer for one scanline, looks each
// character up in the shared 8x8 font and streams the selected glyph row
// MSB-first as pixels under a valid/ready handshake.
// Optional feature macro: GLYPH_FLAG_HILITE_EN adds the pix_flag output,
// which marks pixels belonging to the flag glyph (code 200).
module glyph_line_scheduler #(
    parameter int NUM_CHARS = 16,
    parameter int AW        = $clog2(NUM_CHARS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    glyph_row,
    output logic [AW-1:0] txt_addr,
    input  logic [7:0]    txt_data,
    output logic [7:0]    font_code,
    output logic [2:0]    font_row,
    input  logic [7:0]    font_bits,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_on,
`ifdef GLYPH_FLAG_HILITE_EN
    output logic          pix_flag,
`endif
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        GLYPH = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_CHARS - 1);
    localparam logic [7:0]    FLAG_CODE = 8'd200;

    state_t        state;
    state_t        nxt;
    logic [AW-1:0] idx;
    logic [2:0]    row_q;
    logic [7:0]    code_q;
    logic [2:0]    font_row_q;
    logic [7:0]    sr;
    logic [2:0]    pc;
    logic          xfer;
    logic          last_pix;

    // A pixel moves only while in SHIFT with the consumer ready
    assign xfer     = (state == SHIFT) && pix_ready;
    assign last_pix = xfer && (pc == 3'd7);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        nxt       = state;
        pix_valid = 1'b0;
        pix_on    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) nxt = FETCH;
            end
            FETCH: nxt = LOAD;
            LOAD:  nxt = GLYPH;
            GLYPH: nxt = SHIFT;
            SHIFT: begin
                pix_valid = 1'b1;
                pix_on    = sr[7];
                if (last_pix) nxt = (idx == LAST_IDX) ? DONE : FETCH;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Visible control registers: char index and the font lookup operands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            code_q     <= '0;
            font_row_q <= '0;
        end else begin
            if (state == IDLE && start) idx <= '0;
            if (last_pix && idx != LAST_IDX) idx <= idx + 1'b1;
            if (state == LOAD) begin
                code_q     <= txt_data;
                font_row_q <= row_q;
            end
        end
    end

    // Line row capture, glyph shift register and pixel counter
    always_ff @(posedge clk) begin
        if (state == IDLE && start) row_q <= glyph_row;
        if (state == GLYPH) begin
            sr <= font_bits;
            pc <= 3'd0;
        end else if (xfer) begin
            sr <= {sr[6:0], 1'b0};
            pc <= pc + 3'd1;
        end
    end

    assign txt_addr  = idx;
    assign font_code = code_q;
    assign font_row  = font_row_q;

`ifdef GLYPH_FLAG_HILITE_EN
    assign pix_flag = pix_valid && (code_q == FLAG_CODE);
`endif

endmodule

// File: doc/glyph_line_scheduler.md
# glyph_line_scheduler

Sequences one scanline of text through the shared 8×8 font lookup. On each `start` it walks a character buffer of `NUM_CHARS` entries, reads each character code, drives the font with that code and the selected glyph row, and serialises the returned 8-bit row MSB-first as a pixel stream under a valid/ready handshake. It sits between the status-bar text buffer and the VGA pixel mixer, and is the only driver of the font lookup inputs.

## Interface
Parameters:
- `NUM_CHARS`, default 16: characters per scanline; legal range 2–64.
- `AW`, default `$clog2(NUM_CHARS)`: text buffer address width.

Ports:
- `clk` in 1: system clock. All logic is synchronous to the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request to render a line. Ignored unless `busy`=0.
- `glyph_row` in 3: row of the glyph to render (0–7). Sampled only on an accepted `start`.
- `txt_addr` out AW: text buffer read address.
- `txt_data` in 8: character code. Valid exactly one cycle after `txt_addr` is driven.
- `font_code` out 8: character code presented to the font lookup.
- `font_row` out 3: glyph row presented to the font lookup.
- `font_bits` in 8: combinational font row. Bit 7 is the leftmost pixel.
- `pix_valid` out 1: pixel available.
- `pix_ready` in 1: consumer accepts the pixel.
- `pix_on` out 1: pixel value (1 = foreground).
- `pix_flag` out 1: current glyph is the flag glyph (code 200). Present only with `GLYPH_FLAG_HILITE_EN`.
- `busy` out 1: high from the cycle after an accepted `start` through the `DONE` cycle.
- `done` out 1: one-cycle pulse after the last pixel of the line is accepted.

## Operation
- States: `IDLE`, `FETCH`, `LOAD`, `GLYPH`, `SHIFT`, `DONE`.
- `IDLE`:
  - On `start`, capture `glyph_row` into `row_q`, clear the char index `idx` to 0, go to `FETCH`.
- `FETCH`: drive `txt_addr=idx`, go to `LOAD`.
- `LOAD`: capture `txt_data` into `code_q`, go to `GLYPH`.
- `GLYPH`:
  - `font_code=code_q`, `font_row=row_q`.
  - Load `font_bits` into the 8-bit shift register `sr`, clear the pixel counter `pc` (3 bits), go to `SHIFT`.
- `SHIFT`:
  - `pix_valid`=1, `pix_on=sr[7]`.
  - On `pix_valid && pix_ready`: shift `sr` left by 1 and increment `pc`.
  - When the transfer occurs with `pc`=7:
    - if `idx`=`NUM_CHARS`-1, go to `DONE`;
    - else increment `idx` and go to `FETCH`.
- `DONE`: assert `done` for one cycle, go to `IDLE`.
- `font_code` and `font_row` are registered copies of `code_q` and `row_q`. They hold their last values outside `GLYPH`/`SHIFT`.
- `txt_addr` holds `idx` in all states.
- Index and counter arithmetic is unsigned; `idx` never wraps within a line.

## Timing
- Reset values: `txt_addr`=0, `font_code`=0, `font_row`=0, `pix_valid`=0, `pix_on`=0, `pix_flag`=0, `busy`=0, `done`=0. State returns to `IDLE`.
- `start` accepted at cycle 0 → `FETCH` at cycle 1, `LOAD` at 2, `GLYPH` at 3, first `pix_valid` at cycle 4.
- With `pix_ready` held high:
  - each character takes 11 cycles (3 setup + 8 pixels);
  - the line takes 11·`NUM_CHARS` cycles;
  - `done` fires at cycle 11·`NUM_CHARS`+1.
- Handshake: while `pix_valid`=1 and `pix_ready`=0, `pix_on`, `pix_flag` and all state hold unchanged. `pix_valid` never drops without a transfer.
- `start` while `busy`=1 is ignored.
- `start` in the `DONE` cycle is ignored. `busy` is still 1 in `DONE` and falls in the cycle after it.
- A change of `glyph_row` mid-line has no effect.
- `rst_n` low in any state takes effect at the next edge and aborts the line; no `done` is produced.

## Configuration
- `GLYPH_FLAG_HILITE_EN` defined:
  - `pix_flag` port exists.
  - `pix_flag` = (`code_q`==200) whenever `pix_valid`=1; otherwise 0.
  - The mixer uses it to colour the flag glyph.
- Not defined:
  - port and comparator are removed.
  - All other behaviour is identical.

## Test plan
- Reset mid-line: assert `rst_n`=0 during `SHIFT` of char 5 → next cycle `pix_valid`=0, `busy`=0, `done` never pulses; a fresh `start` renders from `idx` 0.
- Basic line: `NUM_CHARS`=16, buffer "0123456789ABCDEF", `glyph_row`=0, `pix_ready`=1 → first 8 pixels 00011000 for '0'? No: '0' row 0 is 00111100, so first 8 pixels are 0,0,1,1,1,1,0,0; `done` at cycle 177.
- Backpressure: `pix_ready` toggling 1/0 every cycle, buffer all 'H', `glyph_row`=3 → every char emits 01111110, no pixel is duplicated or dropped, and `pix_on` is stable while stalled.
- Start collision: pulse `start` at cycles 0, 5 and 177 (the `DONE` cycle) → exactly one line and one `done`.
- Flag highlight (macro on): buffer char 2 = 200, `glyph_row`=1 → `pix_flag`=1 for exactly pixels 16–23, and those pixels read 00111110.
- Row capture: `start` with `glyph_row`=6, then change `glyph_row` to 0 at cycle 2 → all chars render row 6; '1' emits 01111110.
